// File: rtl/fair_grant_arbiter.sv
// Round-robin arbiter with a post-reset warm-up period and a bounded grant hold time.
// A releasing requester moves to lowest priority for the next arbitration.
module fair_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 3,
    parameter int WARMUP   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 ready,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);

    localparam int OW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_warm;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   w_ptr_nxt;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_nxt;
    logic            w_ready;
    logic            w_release;
    logic            w_pick_vld;
    logic [OW-1:0]   w_pick_idx;
    logic [OW:0]     w_cand;

    assign w_ready   = (r_warm == 32'(WARMUP));
    assign w_release = (r_state == S_GRANT) &&
                       (!req[r_owner] || (r_hold == HW'(MAX_HOLD - 1)));

    // Search upward from r_ptr with wrap; the extra bit of w_cand absorbs the overflow.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = {1'b0, r_ptr} + (OW+1)'(k);
            if (w_cand >= (OW+1)'(N)) begin
                w_cand = w_cand - (OW+1)'(N);
            end
            if (!w_pick_vld && req[w_cand[OW-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand[OW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_ready && w_pick_vld) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
                    w_hold_nxt  = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;
                end else begin
                    w_hold_nxt  = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_warm  <= '0;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_warm  <= (r_warm < 32'(WARMUP)) ? r_warm + 32'd1 : r_warm;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign ready = w_ready;
    assign owner = r_owner;
    assign busy  = (r_state == S_GRANT);

    p4_onehot_gnt: assert property (@(posedge clock) $onehot0(gnt));
    p5_warm_bound: assert property (@(posedge clock) r_warm <= 32'(WARMUP));

`ifdef FORMAL
    p0_trivial:   assert property (@(posedge clock) s_eventually 1'b1);
    p1_ready:     assert property (@(posedge clock) s_eventually ready);
    p2_warm_done: assert property (@(posedge clock) s_eventually (r_warm == 32'(WARMUP)));
    for (genvar gi = 0; gi < N; gi++) begin : g_live
        p3_service: assert property (@(posedge clock)
            req[gi] |-> s_eventually (gnt[gi] || !req[gi]));
    end
`endif

endmodule

// File: tb/tb_fair_grant_arbiter.sv
// Directed bench for fair_grant_arbiter: literal grant timelines plus a
// round-robin reference model checked against the DUT every cycle.
module tb_fair_grant_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 3;
    localparam int WARMUP   = 5;

    logic         clock;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         ready;
    logic [1:0]   owner;
    logic         busy;

    int checks = 0;
    int errors = 0;

    fair_grant_arbiter #(
        .N(N),
        .MAX_HOLD(MAX_HOLD),
        .WARMUP(WARMUP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .gnt(gnt),
        .ready(ready),
        .owner(owner),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: cycles-since-reset, who holds the grant, how many more
    // cycles it may keep it, and where the next round-robin search starts.
    int           m_warm  = 0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    int           m_left  = 0;
    bit           m_busy  = 1'b0;
    bit           m_init  = 1'b0;
    logic [N-1:0] m_gnt;

    always_comb m_gnt = m_busy ? N'(1 << m_owner) : '0;

    always @(posedge clock) begin : model
        int  nw, no, np, nl;
        bit  nb, found;
        if (reset) begin
            m_warm  <= 0;
            m_owner <= 0;
            m_ptr   <= 0;
            m_left  <= 0;
            m_busy  <= 1'b0;
            m_init  <= 1'b1;
        end else begin
            nw = (m_warm < WARMUP) ? m_warm + 1 : WARMUP;
            no = m_owner;
            np = m_ptr;
            nl = m_left;
            nb = m_busy;
            if (m_busy) begin
                if (!req[m_owner] || m_left == 0) begin
                    nb = 1'b0;
                    np = (m_owner + 1) % N;
                end else begin
                    nl = m_left - 1;
                end
            end else if (m_warm == WARMUP && req != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        no    = (m_ptr + k) % N;
                    end
                end
                nb = 1'b1;
                nl = MAX_HOLD - 1;
            end
            m_warm  <= nw;
            m_owner <= no;
            m_ptr   <= np;
            m_left  <= nl;
            m_busy  <= nb;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_init) begin
            chk("gnt_vs_model",   32'(gnt),   32'(m_gnt));
            chk("ready_vs_model", 32'(ready), 32'(m_warm == WARMUP));
            chk("busy_vs_model",  32'(busy),  32'(m_busy));
            chk("owner_vs_model", 32'(owner), 32'(m_owner));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic lit(input string name, input logic [N-1:0] exp);
        chk(name, 32'(gnt), 32'(exp));
        chk({name, "_model"}, 32'(m_gnt), 32'(exp));
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        reset = 1'b1;
        req   = r;
        tick();
        reset = 1'b0;
    endtask

    logic [N-1:0] exp30 [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    logic [N-1:0] exp31 [17] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                                 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                                 4'b0001};

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        lit("rst_gnt", 4'b0000);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        reset = 1'b0;

        // idle warm-up: ready rises after exactly WARMUP cycles and stays
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk($sformatf("warm_ready_%0d", t), 32'(ready), (t < 5) ? 32'd0 : 32'd1);
        end
        repeat (15) tick();
        chk("warm_hold_ready", 32'(ready), 32'd1);
        lit("warm_hold_gnt", 4'b0000);

        // single requester from reset: 3-cycle hold, one idle cycle, re-grant
        do_reset(4'b0001);
        for (int t = 1; t <= 10; t++) begin
            tick();
            lit($sformatf("single_t%0d", t), exp30[t-1]);
        end

        // all requesting: round-robin rotation
        do_reset(4'b0000);
        repeat (5) tick();
        req = 4'b1111;
        for (int t = 6; t <= 22; t++) begin
            tick();
            lit($sformatf("rr_t%0d", t), exp31[t-6]);
        end

        // early release by dropping the request
        do_reset(4'b0000);
        repeat (5) tick();
        req = 4'b0110;
        tick();
        lit("drop_g1", 4'b0010);
        req = 4'b0100;
        tick();
        lit("drop_idle", 4'b0000);
        tick();
        lit("drop_g2", 4'b0100);
        chk("drop_owner", 32'(owner), 32'd2);

        // reset during a grant: drop at once, then full warm-up again
        reset = 1'b1;
        tick();
        lit("midrst_gnt", 4'b0000);
        chk("midrst_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            lit($sformatf("midrst_t%0d", t), (t < 6) ? 4'b0000 : 4'b0100);
        end

        // request drop coinciding with hold expiry: pointer advances only once
        do_reset(4'b0011);
        repeat (5) tick();
        tick();
        lit("coin_g0", 4'b0001);
        tick();
        tick();
        lit("coin_g2", 4'b0001);
        req = 4'b0110;
        tick();
        lit("coin_idle", 4'b0000);
        tick();
        lit("coin_next", 4'b0010);

        // pseudo-random traffic with occasional resets, checked by the model
        for (int i = 0; i < 400; i++) begin
            req   = N'($urandom_range(0, 15));
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
